counter_mod_10: RTL and testbench
=================================

Name: counter_mod_10

Overview:
- Single-digit BCD down-counter (0..9) for the microwave timer's seconds/minutes chain.
- Holds one decimal digit and decrements it once per enabled clock.
- Can be parallel-loaded from the keypad digit or cleared.
- Flags zero and terminal count (borrow) so digits cascade into a multi-digit timer.

Parameters:
- None. Width fixed at 4 bits, modulus fixed at 10.

Ports:
- clk  input  1  rising-edge clock.
- clearn  input  1  asynchronous active-low clear; forces the digit to 0.
- data  input  4  BCD digit to load.
- loadn  input  1  synchronous active-low parallel load.
- EN  input  1  active-high count enable.
- ones  output  4  current BCD digit, 0..9.
- tc  output  1  terminal count / borrow-out to the next digit.
- zero  output  1  high when ones == 0.

Behaviour:
- Reset: clearn=0 immediately forces ones=0, without waiting for clk. While clearn=0, ones holds at 0 regardless of clk, loadn, EN or data. clearn release is synchronised by the clk edge; the first action happens on the first rising edge with clearn=1.
- Priority at each rising clk edge with clearn=1 is, highest first:
  1. loadn=0: ones <= data. Load happens whether EN is 0 or 1.
  2. loadn=1 and EN=1: count down.
  3. Otherwise: hold.
- Load clamp: data values 10..15 (non-BCD) load as 9. ones must never leave 0..9.
- Count down: ones <= ones-1 when ones>0. When ones=0 it wraps to 9.
- Latency: one clock from a load or count edge to the updated ones. Output is registered; no combinational path from data to ones.
- zero: combinational, zero = (ones==0). Asserted during and after reset.
- tc: combinational, tc = EN & (ones==0) & loadn. tc is high exactly in the cycle whose next edge produces the 0->9 wrap, so the next-higher digit uses it as its EN.
- Simultaneous loadn=0 and EN=1: load wins; no decrement; tc=0.
- clearn asserted mid-count or mid-load: the clear wins immediately; the pending edge is discarded.
- X/undefined inputs are not required to be handled.

Decomposition:
- Shared timer package:
  - BCD_MAX = 4'd9
  - BCD_ZERO = 4'd0
  - a 4-bit bcd_digit_t typedef, reused by the seconds and minutes digits
- Sub-module: bcd_clamp, a combinational block mapping 10..15 to 9 for the load path. Everything else stays in the single counter_mod_10 module.

Test Plan:
1. Load: clearn=1, EN=1, loadn=0, data=9, one rising edge -> ones=9, zero=0, tc=0.
2. Async clear: with ones=9, drive clearn=0 between edges -> ones=0 and zero=1 before the next edge; ones stays 0 across two edges while clearn=0.
3. Wrap count: from ones=0, clearn=1, loadn=1, EN=1, 15 edges -> sequence 9,8,...,0,9,8,7,6,5. tc=1 only in the cycles where ones=0.
4. Hold: ones=5, EN=0, loadn=1, 3 edges -> ones stays 5, tc=0.
5. Load priority and clamp:
   - loadn=0, EN=1, data=12, one edge -> ones=9.
   - Then loadn=0, EN=0, data=3, one edge -> ones=3.
6. Clear dominance: clearn=0 and loadn=0 with data=7 on the same edge -> ones=0. Releasing clearn then counting from 0 -> next value 9.

Source files
------------

// File: rtl/counter_mod_10_pkg.sv
// Shared timer package: BCD digit type and constants for the seconds/minutes chain.
package counter_mod_10_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Modulo-10 decrement: 0 wraps to 9.
  function automatic bcd_digit_t bcd_dec(input bcd_digit_t d);
    bcd_digit_t r;
    if (d == BCD_ZERO) r = BCD_MAX;
    else               r = bcd_digit_t'(d - 4'd1);
    return r;
  endfunction

endpackage : counter_mod_10_pkg

// File: rtl/counter_mod_10_bcd_clamp.sv
// Combinational clamp for the load path: non-BCD codes 10..15 become 9.
module bcd_clamp
  import counter_mod_10_pkg::*;
(
  input  bcd_digit_t data_i,
  output bcd_digit_t data_c
);

  always_comb begin
    data_c = data_i;
    if (data_i > BCD_MAX) data_c = BCD_MAX;
  end

endmodule : bcd_clamp

// File: rtl/counter_mod_10.sv
// Single BCD down-counter digit with load, async clear, zero and borrow-out flags.
module counter_mod_10
  import counter_mod_10_pkg::*;
(
  input  logic                clk,
  input  logic                clearn,
  input  logic [DIGIT_W-1:0]  data,
  input  logic                loadn,
  input  logic                EN,
  output logic [DIGIT_W-1:0]  ones,
  output logic                tc,
  output logic                zero
);

  bcd_digit_t ones_q;
  bcd_digit_t ones_d;
  bcd_digit_t load_val;

  bcd_clamp u_clamp (
    .data_i (bcd_digit_t'(data)),
    .data_c (load_val)
  );

  // Load beats count; count beats hold.
  always_comb begin
    ones_d = ones_q;
    if (!loadn)  ones_d = load_val;
    else if (EN) ones_d = bcd_dec(ones_q);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) ones_q <= BCD_ZERO;
    else         ones_q <= ones_d;
  end

  assign ones = ones_q;
  assign zero = (ones_q == BCD_ZERO);
  // Borrow is only meaningful when the next edge will actually wrap 0->9.
  assign tc   = EN & zero & loadn;

endmodule : counter_mod_10

// File: tb/tb_counter_mod_10.sv
// Directed self-checking bench for the counter_mod_10 BCD digit.
module tb_counter_mod_10;

  logic       clk;
  logic       clearn;
  logic [3:0] data;
  logic       loadn;
  logic       EN;
  logic [3:0] ones;
  logic       tc;
  logic       zero;

  int checks   = 0;
  int failures = 0;

  counter_mod_10 dut (
    .clk    (clk),
    .clearn (clearn),
    .data   (data),
    .loadn  (loadn),
    .EN     (EN),
    .ones   (ones),
    .tc     (tc),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_ones,
                         input logic e_zero, input logic e_tc);
    chk({tag, "_ones"}, ones, e_ones);
    chk({tag, "_zero"}, 4'(zero), 4'(e_zero));
    chk({tag, "_tc"},   4'(tc),   4'(e_tc));
  endtask

  logic [3:0] wrap_seq [15] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2,
                                4'd1, 4'd0, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5};

  initial begin
    clearn = 1'b0;
    loadn  = 1'b1;
    EN     = 1'b0;
    data   = 4'd0;

    // Reset state across edges
    repeat (2) @(negedge clk);
    chk_all("reset", 4'd0, 1'b1, 1'b0);

    // 1. Load 9 with EN=1
    clearn = 1'b1; EN = 1'b1; loadn = 1'b0; data = 4'd9;
    #1;
    chk_all("pre_load", 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk_all("load9", 4'd9, 1'b0, 1'b0);

    // 2. Async clear between edges, held across two edges
    #2 clearn = 1'b0;
    #1;
    chk_all("async_clr", 4'd0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk_all("clr_hold", 4'd0, 1'b1, 1'b0);

    // 3. Wrap count from 0 for 15 edges
    clearn = 1'b1; loadn = 1'b1; EN = 1'b1;
    #1;
    chk_all("wrap_pre", 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk_all($sformatf("wrap%0d", i), wrap_seq[i], wrap_seq[i] == 4'd0,
              wrap_seq[i] == 4'd0);
    end

    // 4. Hold with EN=0
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("hold%0d", i), 4'd5, 1'b0, 1'b0);
    end

    // 5. Load priority and clamp; data must not reach ones before the edge
    loadn = 1'b0; EN = 1'b1; data = 4'd12;
    #1;
    chk_all("no_comb_path", 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("clamp12", 4'd9, 1'b0, 1'b0);
    EN = 1'b0; data = 4'd3;
    @(negedge clk);
    chk_all("load3", 4'd3, 1'b0, 1'b0);
    data = 4'd15;
    @(negedge clk);
    chk_all("clamp15", 4'd9, 1'b0, 1'b0);
    data = 4'd0;
    @(negedge clk);
    chk_all("load0", 4'd0, 1'b1, 1'b0);
    data = 4'd10; EN = 1'b1;
    #1;
    chk_all("load_tc0", 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk_all("clamp10", 4'd9, 1'b0, 1'b0);

    // One plain decrement from 9
    loadn = 1'b1;
    @(negedge clk);
    chk_all("dec9", 4'd8, 1'b0, 1'b0);

    // 6. Clear dominates a load on the same edge, then count from 0
    clearn = 1'b0; loadn = 1'b0; data = 4'd7;
    @(negedge clk);
    chk_all("clr_vs_load", 4'd0, 1'b1, 1'b0);
    clearn = 1'b1; loadn = 1'b1; EN = 1'b1;
    @(negedge clk);
    chk_all("post_clr_cnt", 4'd9, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter_mod_10
